// File: rtl/poly_drv_pkg.sv
// Shared constants for the polynomial operand driver: FSM encodings, operand
// slot indices and elaboration-time helpers for the timing parameters.
package poly_drv_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] GO_HI    = 3'd2;
  localparam logic [2:0] GO_LO    = 3'd3;
  localparam logic [2:0] WAIT_RES = 3'd4;
  localparam logic [2:0] CAPTURE  = 3'd5;

  localparam logic [1:0] OP_A = 2'd0;
  localparam logic [1:0] OP_B = 2'd1;
  localparam logic [1:0] OP_C = 2'd2;
  localparam logic [1:0] OP_X = 2'd3;

  function automatic int clamp_min(input int v, input int lo);
    return (v < lo) ? lo : v;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/poly_drv_timer.sv
// Loadable down-counter shared by every hold phase; zero marks the last cycle
// of the phase that loaded it.
module poly_drv_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/poly_operand_driver.sv
// Drives the evaluator's go/data_in load protocol for one {A,B,C,X} set and
// captures its result. Define POLY_DRV_CHECK_EN to add a reference model and mismatch flag.
module poly_operand_driver
  import poly_drv_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SETUP_CYC   = 2,
  parameter int GO_HIGH_CYC = 2,
  parameter int GO_LOW_CYC  = 2,
  parameter int RESULT_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] c_in,
  input  logic [DATA_W-1:0] x_in,
  output logic              busy,
  output logic              go_out,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] eval_result,
  output logic [DATA_W-1:0] result,
  output logic              result_valid
`ifdef POLY_DRV_CHECK_EN
  , output logic            mismatch
`endif
);

  localparam int SC   = clamp_min(SETUP_CYC, 1);
  localparam int GH   = clamp_min(GO_HIGH_CYC, 1);
  localparam int GL   = clamp_min(GO_LOW_CYC, 1);
  localparam int RW   = clamp_min(RESULT_WAIT, 6);
  localparam int MAXP = max4(SC, GH, GL, RW);
  localparam int TW   = $clog2(MAXP) + 1;

  logic [2:0]                   state, state_nxt;
  logic [1:0]                   idx;
  logic [3:0][DATA_W-1:0]       ops;
  logic                         load, zero, accept;
  logic [TW-1:0]                load_val;

  assign accept = (state == IDLE) && start && !busy;

  poly_drv_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (reset),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  // Timer holds N-1 on entry so each phase lasts exactly its parameter in cycles.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_val  = '0;
    case (state)
      IDLE:     if (accept) begin state_nxt = SETUP; load = 1'b1; load_val = TW'(SC - 1); end
      SETUP:    if (zero)   begin state_nxt = GO_HI; load = 1'b1; load_val = TW'(GH - 1); end
      GO_HI:    if (zero)   begin state_nxt = GO_LO; load = 1'b1; load_val = TW'(GL - 1); end
      GO_LO:    if (zero) begin
                  load = 1'b1;
                  if (idx == OP_X) begin state_nxt = WAIT_RES; load_val = TW'(RW - 1); end
                  else             begin state_nxt = SETUP;    load_val = TW'(SC - 1); end
                end
      WAIT_RES: if (zero)   state_nxt = CAPTURE;
      CAPTURE:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= OP_A;
      ops          <= '0;
      busy         <= 1'b0;
      go_out       <= 1'b0;
      data_out     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      go_out       <= (state_nxt == GO_HI);
      // Busy spans the result_valid cycle so a start there is dropped.
      busy         <= (state_nxt != IDLE) || (state == CAPTURE);
      result_valid <= (state == CAPTURE);
      if (accept) begin
        ops      <= {x_in, c_in, b_in, a_in};
        idx      <= OP_A;
        data_out <= a_in;
      end else if (state == GO_LO && state_nxt == SETUP) begin
        idx      <= idx + 2'd1;
        data_out <= ops[idx + 2'd1];
      end
      if (state == CAPTURE) result <= eval_result;
    end
  end

`ifdef POLY_DRV_CHECK_EN
  logic [DATA_W-1:0] cx, cxx, bx, model;

  always_comb begin
    cx    = ops[OP_C] * ops[OP_X];
    cxx   = cx * ops[OP_X];
    bx    = ops[OP_B] * ops[OP_X];
    model = cxx + bx + ops[OP_A];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                mismatch <= 1'b0;
    else if (accept)          mismatch <= 1'b0;
    else if (state == CAPTURE) mismatch <= (eval_result != model);
  end
`endif

endmodule
